// File: rtl/ldtu_output_mode_sequencer.sv
// Output-mode sequencer for the 32-bit LDTU output word mux: selects normal DTU
// data, ADC calibration (with idle guard intervals) or ATU test words.
module ldtu_output_mode_sequencer #(
  parameter int unsigned GUARD_CYCLES = 8,
  parameter int unsigned CAL_TIMEOUT  = 1023,
  parameter int unsigned DRAIN_MAX    = 255,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CAL_REQ,
  input  logic       CAL_DONE,
  input  logic       TEST_REQ,
  input  logic       DTU_FRAME_END,
  output logic       CALIBRATION_BUSY,
  output logic       TEST_ENABLE,
  output logic       CAL_GRANT,
  output logic [2:0] MODE_STATE,
  output logic       CAL_TIMEOUT_ERR
);

  typedef enum logic [2:0] {
    ST_NORMAL     = 3'd0,
    ST_DRAIN_CAL  = 3'd1,
    ST_GUARD_IN   = 3'd2,
    ST_CAL        = 3'd3,
    ST_GUARD_OUT  = 3'd4,
    ST_DRAIN_TEST = 3'd5,
    ST_TEST       = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] GUARD_LAST   = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(CAL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST   = CNT_W'(DRAIN_MAX - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             timed;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= ST_GUARD_OUT;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    timed   = 1'b0;
    case (state_q)
      ST_NORMAL: begin
        if (CAL_REQ)       state_d = ST_DRAIN_CAL;
        else if (TEST_REQ) state_d = ST_DRAIN_TEST;
      end
      ST_DRAIN_CAL: begin
        timed = 1'b1;
        if (!CAL_REQ)                                 state_d = ST_NORMAL;
        else if (DTU_FRAME_END || cnt_q == DRAIN_LAST) state_d = ST_GUARD_IN;
      end
      ST_GUARD_IN: begin
        timed = 1'b1;
        if (cnt_q == GUARD_LAST) state_d = ST_CAL;
      end
      ST_CAL: begin
        timed = 1'b1;
        if (CAL_DONE || !CAL_REQ) begin
          state_d = ST_GUARD_OUT;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = ST_GUARD_OUT;
          err_d   = 1'b1;
        end
      end
      ST_GUARD_OUT: begin
        timed = 1'b1;
        if (cnt_q == GUARD_LAST) state_d = ST_NORMAL;
      end
      ST_DRAIN_TEST: begin
        timed = 1'b1;
        // A calibration request preempts a pending test switch, but not an active test.
        if (!TEST_REQ)                                state_d = ST_NORMAL;
        else if (CAL_REQ)                             state_d = ST_DRAIN_CAL;
        else if (DTU_FRAME_END || cnt_q == DRAIN_LAST) state_d = ST_TEST;
      end
      ST_TEST: begin
        if (!TEST_REQ) state_d = ST_GUARD_OUT;
      end
      default: state_d = ST_GUARD_OUT;
    endcase

    if (state_d != state_q) cnt_d = '0;
    else if (timed)         cnt_d = cnt_q + CNT_W'(1);
    else                    cnt_d = cnt_q;
  end

  always_comb begin
    CALIBRATION_BUSY = 1'b0;
    TEST_ENABLE      = 1'b0;
    CAL_GRANT        = 1'b0;
    case (state_q)
      ST_GUARD_IN, ST_GUARD_OUT: CALIBRATION_BUSY = 1'b1;
      ST_CAL: begin
        CALIBRATION_BUSY = 1'b1;
        CAL_GRANT        = 1'b1;
      end
      ST_TEST: TEST_ENABLE = 1'b1;
      default: ;
    endcase
  end

  assign MODE_STATE      = state_q;
  assign CAL_TIMEOUT_ERR = err_q;

endmodule

// File: doc/ldtu_output_mode_sequencer.md
Name: ldtu_output_mode_sequencer

Overview:
Sequences the select controls (CALIBRATION_BUSY, TEST_ENABLE) of the 32-bit output word mux between three modes: normal DTU data, ADC calibration and ATU test.
- Mode changes happen only at DTU frame boundaries.
- Guard intervals of idle words surround calibration so the back-end receiver keeps word lock.
- Arbitrates between the calibration engine and the slow-control test request.
- Sits between the calibration engine / I2C config block and the 32-bit output mux.

Parameters:
GUARD_CYCLES, 8, number of cycles the idle pattern is forced before entering and after leaving calibration (1..2^CNT_W-1)
CAL_TIMEOUT, 1023, maximum cycles in CAL before forced exit (1..2^CNT_W-1)
DRAIN_MAX, 255, maximum cycles waiting for DTU_FRAME_END before a forced switch (1..2^CNT_W-1)
CNT_W, 16, width of the shared internal cycle counter

Ports:
CLK  in  1  system clock
RST  in  1  reset, synchronous, active-low
CAL_REQ  in  1  level; calibration engine requests the ADC
CAL_DONE  in  1  one-cycle pulse; calibration finished
TEST_REQ  in  1  level; slow-control ATU test mode request
DTU_FRAME_END  in  1  one-cycle pulse; DTU encoder is at a frame boundary
CALIBRATION_BUSY  out  1  to output mux; 1 = idle pattern on lane 0
TEST_ENABLE  out  1  to output mux; 1 = ATU words on lanes 0-3
CAL_GRANT  out  1  to calibration engine; calibration may run
MODE_STATE  out  3  current state encoding, for status register
CAL_TIMEOUT_ERR  out  1  sticky; set on calibration timeout

Behaviour:
- Clock and reset: single clock domain. RST is synchronous, active-low, clock CLK.
- Reset state: GUARD_OUT with counter = 0.
- Reset output values: CALIBRATION_BUSY=1, TEST_ENABLE=0, CAL_GRANT=0, MODE_STATE=4, CAL_TIMEOUT_ERR=0.
- Reset mid-operation: returns to GUARD_OUT from any state. No partial-state carry-over; the error flag is cleared.
- Moore machine: outputs are decoded from the registered state and change in the same cycle the state register updates. Inputs are sampled on the CLK edge, so one cycle of latency from input to output.
- State encoding and outputs (CALIBRATION_BUSY / TEST_ENABLE / CAL_GRANT):
  - 0 NORMAL: 0/0/0
  - 1 DRAIN_CAL: 0/0/0
  - 2 GUARD_IN: 1/0/0
  - 3 CAL: 1/0/1
  - 4 GUARD_OUT: 1/0/0
  - 5 DRAIN_TEST: 0/0/0
  - 6 TEST: 0/1/0
- Counter rules: one shared counter, cleared on every state entry and incremented each cycle while in a timed state.
- Transitions:
  - NORMAL: CAL_REQ=1 -> DRAIN_CAL. Else TEST_REQ=1 -> DRAIN_TEST. Calibration wins when both requests are high together.
  - DRAIN_CAL:
    - CAL_REQ=0 -> NORMAL (abort).
    - Else DTU_FRAME_END=1, or counter = DRAIN_MAX-1 -> GUARD_IN.
  - GUARD_IN: counter = GUARD_CYCLES-1 -> CAL. The state lasts exactly GUARD_CYCLES cycles. CAL_REQ is ignored here.
  - CAL:
    - CAL_DONE=1 or CAL_REQ=0 -> GUARD_OUT.
    - Else counter = CAL_TIMEOUT-1 -> GUARD_OUT and set CAL_TIMEOUT_ERR.
  - GUARD_OUT: counter = GUARD_CYCLES-1 -> NORMAL. Lasts exactly GUARD_CYCLES cycles. Requests are ignored and re-evaluated in NORMAL.
  - DRAIN_TEST:
    - TEST_REQ=0 -> NORMAL.
    - Else CAL_REQ=1 -> DRAIN_CAL (counter cleared).
    - Else DTU_FRAME_END=1, or counter = DRAIN_MAX-1 -> TEST.
  - TEST: TEST_REQ=0 -> GUARD_OUT. CAL_REQ is ignored while in TEST; test mode is never preempted.
- CAL_TIMEOUT_ERR: sticky, cleared only by reset.
- CAL_DONE outside CAL: ignored. DTU_FRAME_END outside the DRAIN states: ignored.
- Invariants:
  - TEST_ENABLE and CAL_GRANT are never high together.
  - CAL_GRANT=1 implies CALIBRATION_BUSY=1.
  - Every exit from CAL or TEST passes through GUARD_OUT.
  - State codes 5 and 6 are never adjacent to CAL without a guard state in between.
  - Illegal state code 7 -> GUARD_OUT on the next cycle.

Test Plan:
- Release reset, no requests -> CALIBRATION_BUSY=1 for exactly 8 cycles, then MODE_STATE=0 and all controls 0.
- In NORMAL: raise CAL_REQ, pulse DTU_FRAME_END 5 cycles later, pulse CAL_DONE 20 cycles into CAL.
  - DRAIN_CAL lasts 6 cycles; then 8 cycles of GUARD_IN.
  - CAL_GRANT=1 for 20 cycles, then 8 cycles of GUARD_OUT, then NORMAL.
- CAL_REQ held, no DTU_FRAME_END, no CAL_DONE:
  - Forced exit from DRAIN_CAL after 255 cycles.
  - CAL lasts 1023 cycles, then CAL_TIMEOUT_ERR=1, which stays 1 through the later return to NORMAL.
- CAL_REQ and TEST_REQ rise in the same cycle -> calibration path taken (MODE_STATE=1) and TEST_ENABLE stays 0.
  - After calibration completes and NORMAL is re-entered with TEST_REQ still high -> DRAIN_TEST, then TEST.
- In TEST, raise CAL_REQ -> no change (TEST_ENABLE=1, CAL_GRANT=0).
  - Drop TEST_REQ -> GUARD_OUT for 8 cycles, then NORMAL, then DRAIN_CAL.
- Assert RST=0 for one cycle while in CAL, with CAL_TIMEOUT_ERR=1 -> next cycle MODE_STATE=4, CAL_GRANT=0, CAL_TIMEOUT_ERR=0. After 8 cycles -> NORMAL.
